// File: rtl/com_bus_arb_pkg.sv
// -----------------------------------------------------------------------------
// com_bus_arb_pkg
// Shared definitions for the common-bus arbiter:
//   - port/core counts and index widths
//   - watchdog limit (only used when ARB_TIMEOUT_EN is defined)
//   - arbiter FSM state enum
//   - small index helpers used by the top level
// -----------------------------------------------------------------------------
package com_bus_arb_pkg;

    localparam int NUM_PROC_PORTS     = 8;   // 4 DL + 4 IL processor-side ports
    localparam int NUM_CORES          = 4;   // snoop-side requesters
    localparam int PTR_W              = 3;   // index into the proc ports
    localparam int CORE_W             = 2;   // index into the cores
    localparam int WDOG_W             = 8;   // watchdog counter width
    localparam int ARB_TIMEOUT_CYCLES = 200; // bus-hold limit before forced release

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PROC  = 2'd1,
        SNOOP = 2'd2,
        MEM   = 2'd3
    } arb_state_e;

    // Index of the set bit of a one-hot proc grant (zero for an all-zero vector).
    function automatic logic [PTR_W-1:0] onehot8_to_idx(input logic [NUM_PROC_PORTS-1:0] oh);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_PROC_PORTS; i++) begin
            if (oh[i]) begin
                idx = idx | PTR_W'(i);
            end
        end
        return idx;
    endfunction

    // Lowest-index requesting core; fixed priority, core 0 highest.
    function automatic logic [CORE_W-1:0] lowest_core(input logic [NUM_CORES-1:0] req);
        logic [CORE_W-1:0] idx;
        idx = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = CORE_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/com_bus_arbiter_rr_pick8.sv
// -----------------------------------------------------------------------------
// rr_pick8
// Combinational round-robin picker: returns a one-hot grant for the first
// requesting port found when scanning upward from ptr_i, wrapping 7 -> 0.
// All-zero output when no port requests.
//   req_i [8] : request vector
//   ptr_i [3] : scan start position (highest priority this round)
//   gnt_o [8] : one-hot-or-zero grant
// -----------------------------------------------------------------------------
module rr_pick8
    import com_bus_arb_pkg::*;
(
    input  logic [NUM_PROC_PORTS-1:0] req_i,
    input  logic [PTR_W-1:0]          ptr_i,
    output logic [NUM_PROC_PORTS-1:0] gnt_o
);

    logic             found;
    logic [PTR_W-1:0] idx;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_PROC_PORTS; i++) begin
            // 3-bit addition wraps naturally past port 7
            idx = ptr_i + PTR_W'(i);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/com_bus_arbiter.sv
// -----------------------------------------------------------------------------
// com_bus_arbiter
// Arbiter for the shared common bus. A processor-side port (round-robin among
// 8) owns the bus; while it owns it, a snooping core (modified-line flush) or
// the lower-level memory may be granted a nested slot. Snoop outranks memory.
// All outputs are registered.
//
// Optional feature: define ARB_TIMEOUT_EN to enable the bus-hold watchdog.
// When enabled, a transaction held for ARB_TIMEOUT_CYCLES cycles is forcibly
// released and the sticky Arb_timeout flag is set. When undefined, grants are
// held indefinitely and Arb_timeout is tied low.
//
// Ports:
//   clk                in   clock, all state updates on posedge
//   RST_N              in   asynchronous active-low reset
//   Com_Bus_Req_proc   in   [8] proc requests (0-3 DL cores, 4-7 IL cores)
//   Com_Bus_Req_snoop  in   [4] per-core snoop flush requests
//   Mem_snoop_req      in   memory requests the bus to return data
//   Com_Bus_Gnt_proc   out  [8] one-hot-or-zero proc grant
//   Com_Bus_Gnt_snoop  out  [4] one-hot-or-zero snoop grant
//   Mem_snoop_gnt      out  memory grant
//   Arb_timeout        out  sticky watchdog flag
// -----------------------------------------------------------------------------
module com_bus_arbiter
    import com_bus_arb_pkg::*;
(
    input  logic                      clk,
    input  logic                      RST_N,
    input  logic [NUM_PROC_PORTS-1:0] Com_Bus_Req_proc,
    input  logic [NUM_CORES-1:0]      Com_Bus_Req_snoop,
    input  logic                      Mem_snoop_req,
    output logic [NUM_PROC_PORTS-1:0] Com_Bus_Gnt_proc,
    output logic [NUM_CORES-1:0]      Com_Bus_Gnt_snoop,
    output logic                      Mem_snoop_gnt,
    output logic                      Arb_timeout
);

    localparam logic [NUM_CORES-1:0] CORE_ONE = NUM_CORES'(1);

    arb_state_e                state_q, state_d;
    logic [PTR_W-1:0]          rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]          owner_q, owner_d;       // current proc owner index
    logic [CORE_W-1:0]         snp_core_q, snp_core_d; // current snoop owner index
    logic                      drop_q, drop_d;         // owner released during nested grant
    logic [NUM_PROC_PORTS-1:0] gnt_proc_q, gnt_proc_d;
    logic [NUM_CORES-1:0]      gnt_snoop_q, gnt_snoop_d;
    logic                      mem_gnt_q, mem_gnt_d;

    logic [NUM_PROC_PORTS-1:0] pick_gnt;
    logic                      owner_req;
    logic                      proc_released;
    logic                      snoop_held;
    logic                      wdog_expire;

    rr_pick8 u_pick (
        .req_i (Com_Bus_Req_proc),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt)
    );

    assign owner_req     = Com_Bus_Req_proc[owner_q];
    // A drop seen in an earlier nested cycle or in this one both count.
    assign proc_released = drop_q | ~owner_req;
    assign snoop_held    = Com_Bus_Req_snoop[snp_core_q];

`ifdef ARB_TIMEOUT_EN
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              timeout_q, timeout_d;

    // Counts edges spent outside IDLE; the edge that would see the limit
    // reached forces the release instead of counting further.
    assign wdog_d      = (state_q == IDLE) ? '0 : wdog_q + WDOG_W'(1);
    assign wdog_expire = (state_q != IDLE) && (wdog_q == WDOG_W'(ARB_TIMEOUT_CYCLES - 1));
    assign timeout_d   = timeout_q | wdog_expire;

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

    assign Arb_timeout = timeout_q;
`else
    assign wdog_expire = 1'b0;
    assign Arb_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (|Com_Bus_Req_proc) begin
                    state_d = PROC;
                end
            end
            PROC: begin
                if (!owner_req) begin
                    state_d = IDLE;
                end else if (|Com_Bus_Req_snoop) begin
                    state_d = SNOOP;
                end else if (Mem_snoop_req) begin
                    state_d = MEM;
                end
            end
            SNOOP: begin
                if (!snoop_held) begin
                    state_d = proc_released ? IDLE : PROC;
                end
            end
            MEM: begin
                if (!Mem_snoop_req) begin
                    state_d = proc_released ? IDLE : PROC;
                end
            end
            default: state_d = IDLE;
        endcase
        if (wdog_expire) begin
            state_d = IDLE;
        end
    end

    // Output / datapath next values (registered below)
    always_comb begin
        gnt_proc_d  = gnt_proc_q;
        gnt_snoop_d = gnt_snoop_q;
        mem_gnt_d   = mem_gnt_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        snp_core_d  = snp_core_q;
        drop_d      = drop_q;

        unique case (state_q)
            IDLE: begin
                // Snoop/memory requests are ignored here: nothing to nest into.
                gnt_proc_d  = pick_gnt;
                gnt_snoop_d = '0;
                mem_gnt_d   = 1'b0;
                drop_d      = 1'b0;
                if (|Com_Bus_Req_proc) begin
                    owner_d = onehot8_to_idx(pick_gnt);
                end
            end
            PROC: begin
                drop_d = 1'b0;
                if (!owner_req) begin
                    gnt_proc_d = '0;
                    rr_ptr_d   = owner_q + PTR_W'(1);
                end else if (|Com_Bus_Req_snoop) begin
                    snp_core_d  = lowest_core(Com_Bus_Req_snoop);
                    gnt_snoop_d = CORE_ONE << lowest_core(Com_Bus_Req_snoop);
                end else if (Mem_snoop_req) begin
                    mem_gnt_d = 1'b1;
                end
            end
            SNOOP: begin
                drop_d = proc_released;
                if (!snoop_held) begin
                    gnt_snoop_d = '0;
                    if (proc_released) begin
                        gnt_proc_d = '0;
                        rr_ptr_d   = owner_q + PTR_W'(1);
                        drop_d     = 1'b0;
                    end
                end
            end
            MEM: begin
                drop_d = proc_released;
                if (!Mem_snoop_req) begin
                    mem_gnt_d = 1'b0;
                    if (proc_released) begin
                        gnt_proc_d = '0;
                        rr_ptr_d   = owner_q + PTR_W'(1);
                        drop_d     = 1'b0;
                    end
                end
            end
            default: begin
                gnt_proc_d  = '0;
                gnt_snoop_d = '0;
                mem_gnt_d   = 1'b0;
                drop_d      = 1'b0;
            end
        endcase

        // Forced release: the stalled owner loses its turn.
        if (wdog_expire) begin
            gnt_proc_d  = '0;
            gnt_snoop_d = '0;
            mem_gnt_d   = 1'b0;
            drop_d      = 1'b0;
            rr_ptr_d    = owner_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            snp_core_q  <= '0;
            drop_q      <= 1'b0;
            gnt_proc_q  <= '0;
            gnt_snoop_q <= '0;
            mem_gnt_q   <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            snp_core_q  <= snp_core_d;
            drop_q      <= drop_d;
            gnt_proc_q  <= gnt_proc_d;
            gnt_snoop_q <= gnt_snoop_d;
            mem_gnt_q   <= mem_gnt_d;
        end
    end

    assign Com_Bus_Gnt_proc  = gnt_proc_q;
    assign Com_Bus_Gnt_snoop = gnt_snoop_q;
    assign Mem_snoop_gnt     = mem_gnt_q;

endmodule

// File: tb/tb_com_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_com_bus_arbiter
// Directed scenarios plus randomized traffic for com_bus_arbiter, compared each
// cycle against a transaction-level reference model (owner / nested holder /
// pointer kept as plain integers).
// -----------------------------------------------------------------------------
module tb_com_bus_arbiter;

`ifdef ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    localparam int TMO_LIMIT = 200;

    logic       clk;
    logic       RST_N;
    logic [7:0] req_proc;
    logic [3:0] req_snoop;
    logic       mem_req;
    logic [7:0] gnt_proc;
    logic [3:0] gnt_snoop;
    logic       mem_gnt;
    logic       arb_tmo;

    int n_checks;
    int n_errors;

    // Reference model state
    int m_owner;   // -1 when the bus is free
    int m_nest;    // 0 none, 1 snoop, 2 memory
    int m_core;
    int m_ptr;
    int m_busy;    // edges spent with an owner
    bit m_lost;    // owner let go while nested grant active
    bit m_tmo;

    com_bus_arbiter dut (
        .clk               (clk),
        .RST_N             (RST_N),
        .Com_Bus_Req_proc  (req_proc),
        .Com_Bus_Req_snoop (req_snoop),
        .Mem_snoop_req     (mem_req),
        .Com_Bus_Gnt_proc  (gnt_proc),
        .Com_Bus_Gnt_snoop (gnt_snoop),
        .Mem_snoop_gnt     (mem_gnt),
        .Arb_timeout       (arb_tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_nest  = 0;
        m_core  = 0;
        m_ptr   = 0;
        m_busy  = 0;
        m_lost  = 1'b0;
        m_tmo   = 1'b0;
    endtask

    task automatic model_release();
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
        m_nest  = 0;
        m_lost  = 1'b0;
    endtask

    // One clock edge of the arbitration rules, using the inputs present at the edge.
    task automatic model_step();
        bit released;
        if (m_owner < 0) begin
            m_busy = 0;
            if (req_proc != 8'h00) begin
                for (int i = 0; i < 8; i++) begin
                    if (m_owner < 0 && req_proc[(m_ptr + i) % 8]) begin
                        m_owner = (m_ptr + i) % 8;
                    end
                end
            end
        end else begin
            m_busy++;
            if (TMO_EN && m_busy == TMO_LIMIT) begin
                m_tmo = 1'b1;
                model_release();
            end else if (m_nest == 0) begin
                if (!req_proc[m_owner]) begin
                    model_release();
                end else if (req_snoop != 4'h0) begin
                    m_nest = 1;
                    m_core = 3;
                    for (int c = 3; c >= 0; c--) begin
                        if (req_snoop[c]) m_core = c;
                    end
                end else if (mem_req) begin
                    m_nest = 2;
                end
            end else begin
                if (!req_proc[m_owner]) m_lost = 1'b1;
                released = (m_nest == 1) ? !req_snoop[m_core] : !mem_req;
                if (released) begin
                    m_nest = 0;
                    if (m_lost) model_release();
                end
            end
        end
    endtask

    task automatic compare_all(input string tag);
        logic [7:0] e_proc;
        logic [3:0] e_snoop;
        e_proc  = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
        e_snoop = (m_nest == 1) ? (4'h1 << m_core) : 4'h0;
        check_val({tag, ".gnt_proc"}, 32'(gnt_proc), 32'(e_proc));
        check_val({tag, ".gnt_snoop"}, 32'(gnt_snoop), 32'(e_snoop));
        check_val({tag, ".mem_gnt"}, 32'(mem_gnt), 32'(m_nest == 2));
        check_val({tag, ".timeout"}, 32'(arb_tmo), 32'(m_tmo));
    endtask

    // Advance one clock, update the model, sample outputs 1 time unit later.
    task automatic cycle(input string tag);
        @(posedge clk);
        if (!RST_N) model_reset();
        else model_step();
        #1;
        compare_all(tag);
    endtask

    task automatic do_reset();
        RST_N     = 1'b0;
        req_proc  = '0;
        req_snoop = '0;
        mem_req   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        RST_N = 1'b1;
    endtask

    initial begin
        int hi_cnt;
        n_checks = 0;
        n_errors = 0;

        // Reset state and the basic round-robin pointer advance
        do_reset();
        req_proc = 8'h05;
        cycle("rr_first");
        check_val("rr_first_gnt", 32'(gnt_proc), 32'h01);
        req_proc = 8'h04;
        cycle("rr_drop0");
        check_val("rr_drop0_gnt", 32'(gnt_proc), 32'h00);
        cycle("rr_next");
        check_val("rr_next_gnt", 32'(gnt_proc), 32'h04);
        req_proc = 8'h00;
        cycle("rr_drop2");
        req_proc = 8'h09;            // ptr now 3: port 3 beats port 0
        cycle("rr_ptr3");
        check_val("rr_ptr3_gnt", 32'(gnt_proc), 32'h08);
        req_proc = 8'h00;
        cycle("rr_end");

        // Full rotation with every port requesting
        do_reset();
        req_proc = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            cycle("rot_gnt");
            check_val("rot_order", 32'(gnt_proc), 32'(8'h01 << (k % 8)));
            cycle("rot_hold1");
            cycle("rot_hold2");
            req_proc[k % 8] = 1'b0;
            cycle("rot_idle");
            check_val("rot_idle_gnt", 32'(gnt_proc), 32'h00);
            req_proc[k % 8] = 1'b1;
        end
        req_proc = 8'h00;
        cycle("rot_end");
        cycle("rot_end2");

        // Snoop outranks memory, nested grants re-arbitrated from PROC
        do_reset();
        req_proc = 8'h04;
        cycle("sn_own");
        req_snoop = 4'b1010;
        mem_req   = 1'b1;
        cycle("sn_first");
        check_val("sn_first_snoop", 32'(gnt_snoop), 32'h2);
        check_val("sn_first_proc", 32'(gnt_proc), 32'h04);
        check_val("sn_first_mem", 32'(mem_gnt), 32'h0);
        cycle("sn_hold");
        req_snoop = 4'b1000;
        cycle("sn_back");
        check_val("sn_back_snoop", 32'(gnt_snoop), 32'h0);
        cycle("sn_second");
        check_val("sn_second_snoop", 32'(gnt_snoop), 32'h8);
        req_snoop = 4'b0000;
        cycle("sn_back2");
        cycle("sn_mem");
        check_val("sn_mem_gnt", 32'(mem_gnt), 32'h1);
        check_val("sn_mem_proc", 32'(gnt_proc), 32'h04);
        mem_req = 1'b0;
        cycle("sn_mem_rel");
        req_proc = 8'h00;
        cycle("sn_end");

        // Owner drops during MEM: release goes straight to idle
        do_reset();
        req_proc = 8'h20;
        cycle("mem_own");
        mem_req = 1'b1;
        cycle("mem_in");
        req_proc = 8'h00;
        cycle("mem_lost");
        check_val("mem_lost_proc", 32'(gnt_proc), 32'h20);
        mem_req = 1'b0;
        cycle("mem_out");
        check_val("mem_out_proc", 32'(gnt_proc), 32'h00);
        check_val("mem_out_mem", 32'(mem_gnt), 32'h0);
        req_proc = 8'h01;             // ptr advanced to 6; port 0 still reachable
        cycle("mem_next");
        check_val("mem_next_proc", 32'(gnt_proc), 32'h01);

        // Asynchronous reset in the middle of a snoop
        do_reset();
        req_proc = 8'h02;
        cycle("ar_own");
        req_snoop = 4'b0001;
        cycle("ar_snoop");
        #2;
        RST_N = 1'b0;
        model_reset();
        #1;
        compare_all("ar_async");
        check_val("ar_async_proc", 32'(gnt_proc), 32'h00);
        @(posedge clk);
        #1;
        req_snoop = 4'b0000;
        RST_N     = 1'b1;
        cycle("ar_first");
        check_val("ar_first_proc", 32'(gnt_proc), 32'h02);
        req_proc = 8'h00;
        cycle("ar_end");

        // Long hold: watchdog behaviour depends on the build
        do_reset();
        req_proc = 8'h02;
        hi_cnt   = 0;
        for (int k = 0; k < 250; k++) begin
            cycle("tmo");
            if (gnt_proc == 8'h02) hi_cnt++;
        end
        check_val("tmo_hold_cycles", 32'(hi_cnt), TMO_EN ? 32'd249 : 32'd250);
        check_val("tmo_flag", 32'(arb_tmo), 32'(TMO_EN));
        req_proc = 8'h00;
        cycle("tmo_end");

        // Randomized traffic
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(5) == 0) req_proc[i] = ~req_proc[i];
            end
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(7) == 0) req_snoop[i] = ~req_snoop[i];
            end
            if ($urandom_range(7) == 0) mem_req = ~mem_req;
            cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
